// File: rtl/timekeeper_if.sv
// Control/status bundle of the timekeeper: mode and adjust controls, load
// request with its values, and the time/pulse outputs.
interface timekeeper_if;
    logic       en;
    logic       updown;
    logic       adj_sec;
    logic       adj_min;
    logic       adj_hour;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hour;
    logic       mode12;
    logic [5:0] secCount;
    logic [5:0] minCount;
    logic [4:0] hourCount;
    logic [4:0] hourDisp;
    logic       pm;
    logic       sec_tick;
    logic       day_tick;
    logic       load_err;

    modport master (
        output en, updown, adj_sec, adj_min, adj_hour, load,
               load_sec, load_min, load_hour, mode12,
        input  secCount, minCount, hourCount, hourDisp, pm,
               sec_tick, day_tick, load_err
    );

    modport slave (
        input  en, updown, adj_sec, adj_min, adj_hour, load,
               load_sec, load_min, load_hour, mode12,
        output secCount, minCount, hourCount, hourDisp, pm,
               sec_tick, day_tick, load_err
    );
endinterface

// File: rtl/timekeeper.sv
// Up/down hh:mm:ss clock with a one-second prescaler, per-field adjust,
// validated parallel load and a 12/24-hour display view.
module timekeeper #(
    parameter int TICK_DIV = 100000000
) (
    input  logic         clk,
    input  logic         rst,
    timekeeper_if.slave  bus
);
    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic          sec_tick_q, sec_tick_d;
    logic          day_tick_q, day_tick_d;
    logic          load_err_q, load_err_d;

    logic term, load_ok, sec_wrap, min_wrap, hour_wrap;

    function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
        if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0)  ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
        if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
        else    return (v == 5'd0)  ? 5'd23 : v - 5'd1;
    endfunction

    assign term    = bus.en && (presc_q == TERM);
    assign load_ok = bus.load && (bus.load_sec <= 6'd59) &&
                     (bus.load_min <= 6'd59) && (bus.load_hour <= 5'd23);

    // A field "wraps" when the next step in the current direction rolls it over.
    assign sec_wrap  = bus.updown ? (sec_q  == 6'd59) : (sec_q  == 6'd0);
    assign min_wrap  = bus.updown ? (min_q  == 6'd59) : (min_q  == 6'd0);
    assign hour_wrap = bus.updown ? (hour_q == 5'd23) : (hour_q == 5'd0);

    always_comb begin
        presc_d    = bus.en ? (term ? '0 : presc_q + PW'(1)) : '0;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        sec_tick_d = term;
        day_tick_d = 1'b0;
        load_err_d = bus.load && !load_ok;

        // Accepted load wins over everything and swallows a coincident tick.
        if (load_ok) begin
            sec_d   = bus.load_sec;
            min_d   = bus.load_min;
            hour_d  = bus.load_hour;
            presc_d = '0;
        end else if (!bus.en) begin
            if (bus.adj_sec)  sec_d  = step60(sec_q,  bus.updown);
            if (bus.adj_min)  min_d  = step60(min_q,  bus.updown);
            if (bus.adj_hour) hour_d = step24(hour_q, bus.updown);
        end else if (term) begin
            sec_d = step60(sec_q, bus.updown);
            if (sec_wrap) begin
                min_d = step60(min_q, bus.updown);
                if (min_wrap) begin
                    hour_d     = step24(hour_q, bus.updown);
                    day_tick_d = hour_wrap;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            load_err_q <= load_err_d;
        end
    end

    always_comb begin
        bus.hourDisp = hour_q;
        if (bus.mode12) begin
            if (hour_q == 5'd0)       bus.hourDisp = 5'd12;
            else if (hour_q > 5'd12)  bus.hourDisp = hour_q - 5'd12;
        end
    end

    assign bus.secCount  = sec_q;
    assign bus.minCount  = min_q;
    assign bus.hourCount = hour_q;
    assign bus.pm        = (hour_q >= 5'd12);
    assign bus.sec_tick  = sec_tick_q;
    assign bus.day_tick  = day_tick_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_timekeeper.sv
// Bench for timekeeper (TICK_DIV=4): directed sequences, a vector table and
// randomized cycles against a seconds-of-day reference model.
module tb_timekeeper;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    timekeeper_if bus();

    timekeeper #(.TICK_DIV(TD)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: time as seconds since midnight plus prescaler phase
    int m_t, m_pc, m_tick, m_day, m_err;

    typedef struct {
        logic en, up, as, am, ah, ld;
        int   ls, lm, lh;
        logic m12;
        int   es, em, eh, ed, epm, etk, eday, eerr;
    } vec_t;

    vec_t vec[16];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int es, input int em, input int eh,
                             input int ed, input int epm, input int etk, input int eday,
                             input int eerr);
        chk({tag, ".sec"},      int'(bus.secCount),  es);
        chk({tag, ".min"},      int'(bus.minCount),  em);
        chk({tag, ".hour"},     int'(bus.hourCount), eh);
        chk({tag, ".hourDisp"}, int'(bus.hourDisp),  ed);
        chk({tag, ".pm"},       int'(bus.pm),        epm);
        chk({tag, ".sec_tick"}, int'(bus.sec_tick),  etk);
        chk({tag, ".day_tick"}, int'(bus.day_tick),  eday);
        chk({tag, ".load_err"}, int'(bus.load_err),  eerr);
    endtask

    task automatic set_in(input logic en, input logic up, input logic as, input logic am,
                          input logic ah, input logic ld, input int ls, input int lm,
                          input int lh, input logic m12);
        bus.en = en; bus.updown = up;
        bus.adj_sec = as; bus.adj_min = am; bus.adj_hour = ah;
        bus.load = ld;
        bus.load_sec = 6'(ls); bus.load_min = 6'(lm); bus.load_hour = 5'(lh);
        bus.mode12 = m12;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_t = 0; m_pc = 0;
    endtask

    function automatic int disp_of(input int h, input int m12);
        return m12 ? ((h + 11) % 12) + 1 : h;
    endfunction

    task automatic model_step(input int en, input int up, input int as, input int am,
                              input int ah, input int ld, input int ls, input int lm,
                              input int lh);
        int h, m, s, d, acc;
        m_tick = (en != 0 && m_pc == TD - 1);
        m_day  = 0;
        m_err  = 0;
        acc    = 0;
        if (ld != 0) begin
            if (ls < 60 && lm < 60 && lh < 24) acc = 1;
            else m_err = 1;
        end
        if (acc != 0) begin
            m_t = lh * 3600 + lm * 60 + ls;
        end else if (en == 0) begin
            h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
            d = (up != 0) ? 1 : -1;
            if (as != 0) s = (s + d + 60) % 60;
            if (am != 0) m = (m + d + 60) % 60;
            if (ah != 0) h = (h + d + 24) % 24;
            m_t = h * 3600 + m * 60 + s;
        end else if (m_tick != 0) begin
            m_day = (up != 0) ? (m_t == 86399) : (m_t == 0);
            m_t   = (m_t + ((up != 0) ? 1 : 86399)) % 86400;
        end
        if (acc != 0)    m_pc = 0;
        else if (en != 0) m_pc = (m_pc + 1) % TD;
        else             m_pc = 0;
    endtask

    initial begin
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset state and first two seconds after release
        cyc();
        check_out("reset", 0, 0, 0, 12, 0, 0, 0, 0);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            check_out($sformatf("run_c%0d", c), c / 4, 0, 0, 12, 0,
                      (c % 4 == 0) ? 1 : 0, 0, 0);
        end

        // Day wrap up then down
        set_in(1, 1, 0, 0, 0, 1, 59, 59, 23, 1);
        cyc();
        check_out("load_235959", 59, 59, 23, 11, 1, 0, 0, 0);
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int c = 1; c <= 4; c++) cyc();
        check_out("wrap_up", 0, 0, 0, 12, 0, 1, 1, 0);
        bus.updown = 1'b0;
        for (int c = 1; c <= 3; c++) cyc();
        check_out("wrap_dn_pre", 0, 0, 0, 12, 0, 0, 0, 0);
        cyc();
        check_out("wrap_dn", 59, 59, 23, 11, 1, 1, 1, 0);
        cyc();
        check_out("wrap_dn_after", 59, 59, 23, 11, 1, 0, 0, 0);

        // Load coincident with sec_tick
        set_in(1, 1, 0, 0, 0, 1, 9, 0, 0, 0);
        cyc();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) cyc();
        check_out("at_0010", 10, 0, 0, 0, 0, 1, 0, 0);
        for (int c = 1; c <= 3; c++) cyc();
        set_in(1, 1, 0, 0, 0, 1, 0, 30, 8, 0);
        cyc();
        check_out("load_on_tick", 0, 30, 8, 8, 0, 1, 0, 0);
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) cyc();
        check_out("after_load_tick", 0, 30, 8, 8, 0, 0, 0, 0);
        cyc();
        check_out("first_sec_after_load", 1, 30, 8, 8, 0, 1, 0, 0);

        // Asynchronous reset mid-second
        set_in(1, 1, 0, 0, 0, 1, 3, 2, 1, 0);
        cyc();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 1; c <= 3; c++) cyc();
        check_out("rst_pre_tick", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        check_out("rst_first_tick", 1, 0, 0, 0, 0, 1, 0, 0);

        // Vector table in adjust mode and load validation
        vec[0]  = '{0,1,0,0,0,1, 58,59,10, 0,  58,59,10,10,0,0,0,0};
        vec[1]  = '{0,1,1,1,1,0,  0, 0, 0, 0,  59, 0,11,11,0,0,0,0};
        vec[2]  = '{0,1,1,1,1,0,  0, 0, 0, 0,   0, 1,12,12,1,0,0,0};
        vec[3]  = '{0,1,0,0,0,1,  7,60, 5, 0,   0, 1,12,12,1,0,0,1};
        vec[4]  = '{0,1,0,0,0,0,  0, 0, 0, 0,   0, 1,12,12,1,0,0,0};
        vec[5]  = '{0,1,0,0,0,1,  7, 6, 5, 0,   7, 6, 5, 5,0,0,0,0};
        vec[6]  = '{0,1,0,0,0,1, 60, 6, 5, 0,   7, 6, 5, 5,0,0,0,1};
        vec[7]  = '{0,1,0,0,0,1,  0, 0,13, 1,   0, 0,13, 1,1,0,0,0};
        vec[8]  = '{0,0,0,0,1,0,  0, 0, 0, 1,   0, 0,12,12,1,0,0,0};
        vec[9]  = '{0,0,0,0,1,0,  0, 0, 0, 1,   0, 0,11,11,0,0,0,0};
        vec[10] = '{0,0,1,1,0,0,  0, 0, 0, 1,  59,59,11,11,0,0,0,0};
        vec[11] = '{0,0,0,0,0,1,  0, 0,24, 1,  59,59,11,11,0,0,0,1};
        vec[12] = '{0,0,0,0,0,1,  0, 0, 0, 1,   0, 0, 0,12,0,0,0,0};
        vec[13] = '{0,0,0,0,1,0,  0, 0, 0, 1,   0, 0,23,11,1,0,0,0};
        vec[14] = '{1,1,1,1,1,0,  0, 0, 0, 1,   0, 0,23,11,1,0,0,0};
        vec[15] = '{1,1,0,0,0,0,  0, 0, 0, 0,   0, 0,23,23,1,0,0,0};
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(vec[i].en, vec[i].up, vec[i].as, vec[i].am, vec[i].ah, vec[i].ld,
                   vec[i].ls, vec[i].lm, vec[i].lh, vec[i].m12);
            cyc();
            check_out($sformatf("vec%0d", i), vec[i].es, vec[i].em, vec[i].eh, vec[i].ed,
                      vec[i].epm, vec[i].etk, vec[i].eday, vec[i].eerr);
        end

        // Randomized cycles against the reference model
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int en, up, as, am, ah, ld, ls, lm, lh, m12, h;
            en  = ($urandom_range(0, 9) < 8) ? 1 : 0;
            up  = ($urandom_range(0, 3) != 0) ? 1 : 0;
            as  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            am  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            ah  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            ld  = ($urandom_range(0, 19) == 0) ? 1 : 0;
            m12 = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                ls = $urandom_range(0, 59); lm = $urandom_range(0, 59); lh = $urandom_range(0, 23);
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0) begin lh = 23; lm = 59; ls = $urandom_range(56, 59); end
                    else begin lh = 0; lm = 0; ls = $urandom_range(0, 3); end
                end
            end else begin
                ls = $urandom_range(0, 63); lm = $urandom_range(0, 63); lh = $urandom_range(0, 31);
            end
            set_in(en[0], up[0], as[0], am[0], ah[0], ld[0], ls, lm, lh, m12[0]);
            model_step(en, up, as, am, ah, ld, ls, lm, lh);
            cyc();
            h = m_t / 3600;
            check_out($sformatf("rand%0d", i), m_t % 60, (m_t / 60) % 60, h,
                      disp_of(h, m12), (h >= 12) ? 1 : 0, m_tick, m_day, m_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/timekeeper.md
TIMEKEEPER -- requirements
Module: timekeeper

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clock cycles per second (legal range 2..2^27).
REQ-002 Port clk  input  1  rising-edge system clock.
REQ-003 Port rst  input  1  reset; asynchronous, active-high.
REQ-004 Port en  input  1  1 = run mode (prescaled counting); 0 = adjust mode.
REQ-005 Port updown  input  1  direction for counting and adjust: 1 = up, 0 = down.
REQ-006 Port adj_sec  input  1  adjust-mode step of seconds field, one step per cycle high.
REQ-007 Port adj_min  input  1  adjust-mode step of minutes field, one step per cycle high.
REQ-008 Port adj_hour  input  1  adjust-mode step of hours field, one step per cycle high.
REQ-009 Port load  input  1  single-cycle request to load load_sec/load_min/load_hour.
REQ-010 Port load_sec  input  6  seconds load value, legal 0..59.
REQ-011 Port load_min  input  6  minutes load value, legal 0..59.
REQ-012 Port load_hour  input  5  hours load value, legal 0..23.
REQ-013 Port mode12  input  1  display format select: 1 = 12-hour, 0 = 24-hour.
REQ-014 Port secCount  output  6  seconds, 0..59.
REQ-015 Port minCount  output  6  minutes, 0..59.
REQ-016 Port hourCount  output  5  hours, always 24-hour internal, 0..23.
REQ-017 Port hourDisp  output  5  displayed hour: equals hourCount when mode12=0; 1..12 when mode12=1.
REQ-018 Port pm  output  1  1 when hourCount >= 12, regardless of mode12.
REQ-019 Port sec_tick  output  1  one-cycle pulse on each prescaler terminal count in run mode.
REQ-020 Port day_tick  output  1  one-cycle pulse on a run-mode day wrap in either direction.
REQ-021 Port load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-022 Prescaler: counts 0..TICK_DIV-1 while en=1; wraps to 0; held at 0 while en=0 or on an accepted load.
REQ-023 sec_tick: asserted in the cycle the prescaler equals TICK_DIV-1 with en=1; time fields update on the same clock edge.
REQ-024 Up count on sec_tick: sec 59->0 carries to min; min 59->0 with carry carries to hour; hour 23->0 with carry.
REQ-025 Down count on sec_tick: sec 0->59 borrows from min; min 0->59 with borrow borrows from hour; hour 0->23 with borrow.
REQ-026 day_tick: asserted with the sec_tick that takes 23:59:59->00:00:00 (up) or 00:00:00->23:59:59 (down); never in adjust mode.
REQ-027 Adjust (en=0): each asserted adj_* steps only its own field by 1 per cycle in the updown direction, wrapping within its range (sec/min 0..59, hour 0..23), with no carry/borrow into other fields.
REQ-028 Adjust: multiple adj_* high in the same cycle each apply independently in that cycle; adj_* ignored when en=1.
REQ-029 Load: accepted when load=1 and all three values are legal; all fields take load values on the next edge, in either mode.
REQ-030 Load rejection: any value out of range -> no field changes, prescaler unaffected, load_err pulses for one cycle.
REQ-031 Priority per cycle: accepted load > adjust step > run-mode count; a sec_tick coinciding with an accepted load is discarded (no count, no day_tick) but still pulses sec_tick.
REQ-032 hourDisp in 12-hour mode: hour 0 -> 12, 1..12 -> same, 13..23 -> hour-12; combinational from hourCount and mode12.
REQ-033 mode12 affects only hourDisp; toggling it never changes registered state.
REQ-034 Outputs secCount/minCount/hourCount/sec_tick/day_tick/load_err are registered.

Reset
REQ-035 On rst=1, immediately and asynchronously: prescaler=0, secCount=0, minCount=0, hourCount=0, sec_tick=0, day_tick=0, load_err=0.
REQ-036 Reset asserted mid-second discards the partial prescaler count; first sec_tick after release occurs TICK_DIV cycles after first edge with en=1.

Verification (TICK_DIV=4)
REQ-037 Reset release, en=1, updown=1, 8 cycles -> sec_tick on cycles 4 and 8, secCount 0->1->2, hourDisp=12 with mode12=1, pm=0.
REQ-038 Load 23:59:59, en=1, updown=1 -> next sec_tick gives 00:00:00 with day_tick=1 same cycle; updown=0 from 00:00:00 -> 23:59:59, day_tick=1, pm=1, hourDisp=11 (mode12=1).
REQ-039 en=0 at 10:59:58, adj_sec+adj_min+adj_hour held 2 cycles, updown=1 -> 12:01:00, no carries, no day_tick, no sec_tick.
REQ-040 load with load_min=60 at 05:06:07 -> fields unchanged, load_err one cycle; load with 13:00:00, mode12=1 -> hourDisp=1, pm=1.
REQ-041 load coincident with sec_tick at 00:00:10 (load 08:30:00) -> 08:30:00, prescaler restarts at 0, no extra second counted.
REQ-042 rst asserted mid-count at 01:02:03, prescaler=2 -> all outputs 0 immediately without a clock edge; next sec_tick 4 cycles after release.
